// File: rtl/write_s_block_pkg.sv
// Shared types and constants for the S-block writer: FSM states, plane
// selection, SRAM plane layout and the S DPRAM layout.
package write_s_block_pkg;

  typedef enum logic [2:0] {
    S_WS_IDLE,
    S_WS_LI0,
    S_WS_LI1,
    S_WS_WRITE,
    S_WS_LO
  } WS_state_type;

  typedef enum logic [1:0] {
    PLANE_Y,
    PLANE_U,
    PLANE_V
  } plane_e;

  // SRAM word addresses of the three planes
  localparam logic [17:0] Y_BASE = 18'd0;
  localparam logic [17:0] U_BASE = 18'd38400;
  localparam logic [17:0] V_BASE = 18'd57600;

  // SRAM words per pixel row (two pixels per word)
  localparam logic [17:0] Y_WORDS_ROW  = 18'd160;
  localparam logic [17:0] UV_WORDS_ROW = 18'd80;

  // Block grid of each plane
  localparam int Y_BLOCK_COLS  = 40;
  localparam int UV_BLOCK_COLS = 20;
  localparam int BLOCK_ROWS    = 30;

  // S is stored row-major, one sample per DPRAM word
  localparam logic [6:0] S_OFFSET       = 7'd0;
  localparam logic [6:0] LAST_PAIR_ADDR = S_OFFSET + 7'd62;

endpackage

// File: rtl/write_s_block_if.sv
// Bus bundle between the S-block writer and its environment (M2 controller,
// S DPRAM read ports, SRAM write port).
//
// Handshake: WS_start is a one-cycle request pulse, honoured only while the
// writer is idle and never queued; WS_done is a one-cycle completion pulse
// issued after the 32nd SRAM write, with WS_memory_end high in that same
// cycle when the block was the last V block. No ready signal exists: the
// controller must not expect a start to be accepted before WS_done.
interface write_s_block_if;
  import write_s_block_pkg::*;

  logic             WS_start;
  logic             WS_done;
  logic             WS_memory_end;
  logic [1:0][6:0]  WS_RAM_address;    // [0] even column, [1] odd column
  logic [1:0][31:0] WS_RAM_read_data;  // signed S samples from ports [0]/[1]
  logic [17:0]      SRAM_address;
  logic [15:0]      SRAM_write_data;   // {even px, odd px}
  logic             SRAM_we_n;
  WS_state_type     ws_state;          // debug view of the writer FSM

  // Environment side: controller plus DPRAM output
  modport master (
    output WS_start, WS_RAM_read_data,
    input  WS_done, WS_memory_end, WS_RAM_address,
    input  SRAM_address, SRAM_write_data, SRAM_we_n, ws_state
  );

  // Writer side
  modport slave (
    input  WS_start, WS_RAM_read_data,
    output WS_done, WS_memory_end, WS_RAM_address,
    output SRAM_address, SRAM_write_data, SRAM_we_n, ws_state
  );

endinterface

// File: rtl/write_s_block_addr_gen.sv
// SRAM address generator: tracks plane / block-row / block-column and builds
// the word address incrementally (row-base accumulator, no multiplier).
module ws_address_gen
  import write_s_block_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_word_i,   // advance one word within a pixel row
  input  logic        step_row_i,    // advance to next pixel row of the block
  input  logic        step_block_i,  // advance to the next block in raster order
  output logic [17:0] addr_o,
  output logic        last_block_o
);

  plane_e      plane_q, plane_d;
  logic [4:0]  brow_q, brow_d;
  logic [5:0]  bcol_q, bcol_d;
  logic [17:0] blk_base_q, blk_base_d;   // first word of the current block-row
  logic [17:0] row_base_q, row_base_d;   // first word of the current pixel row
  logic [7:0]  col_off_q, col_off_d;     // 4 * bcol
  logic [1:0]  col_q, col_d;             // word within the pixel row
  logic [17:0] wpr;
  logic [5:0]  bcol_last;

  // Plane-dependent geometry
  always_comb begin
    wpr       = (plane_q == PLANE_Y) ? Y_WORDS_ROW : UV_WORDS_ROW;
    bcol_last = (plane_q == PLANE_Y) ? 6'(Y_BLOCK_COLS - 1) : 6'(UV_BLOCK_COLS - 1);
  end

  // Counter next-state: block step wins over row step wins over word step
  always_comb begin
    plane_d    = plane_q;
    brow_d     = brow_q;
    bcol_d     = bcol_q;
    blk_base_d = blk_base_q;
    row_base_d = row_base_q;
    col_off_d  = col_off_q;
    col_d      = col_q;
    if (step_block_i) begin
      col_d = 2'd0;
      if (bcol_q == bcol_last) begin
        bcol_d    = 6'd0;
        col_off_d = 8'd0;
        if (brow_q == 5'(BLOCK_ROWS - 1)) begin
          brow_d = 5'd0;
          case (plane_q)
            PLANE_Y: begin plane_d = PLANE_U; blk_base_d = U_BASE; end
            PLANE_U: begin plane_d = PLANE_V; blk_base_d = V_BASE; end
            default: begin plane_d = PLANE_Y; blk_base_d = Y_BASE; end
          endcase
        end else begin
          brow_d     = brow_q + 5'd1;
          blk_base_d = blk_base_q + (wpr << 3);
        end
        row_base_d = blk_base_d;
      end else begin
        bcol_d     = bcol_q + 6'd1;
        col_off_d  = col_off_q + 8'd4;
        row_base_d = blk_base_q;
      end
    end else if (step_row_i) begin
      row_base_d = row_base_q + wpr;
      col_d      = 2'd0;
    end else if (step_word_i) begin
      col_d = col_q + 2'd1;
    end
  end

  // Counter registers, cleared to Y(0,0)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      plane_q    <= PLANE_Y;
      brow_q     <= 5'd0;
      bcol_q     <= 6'd0;
      blk_base_q <= Y_BASE;
      row_base_q <= Y_BASE;
      col_off_q  <= 8'd0;
      col_q      <= 2'd0;
    end else begin
      plane_q    <= plane_d;
      brow_q     <= brow_d;
      bcol_q     <= bcol_d;
      blk_base_q <= blk_base_d;
      row_base_q <= row_base_d;
      col_off_q  <= col_off_d;
      col_q      <= col_d;
    end
  end

  assign addr_o       = row_base_q + 18'(col_off_q) + 18'(col_q);
  assign last_block_o = (plane_q == PLANE_V) && (brow_q == 5'(BLOCK_ROWS - 1)) &&
                        (bcol_q == 6'(UV_BLOCK_COLS - 1));

endmodule

// File: rtl/write_s_block.sv
// Drains one 8x8 S block from the DPRAM, clips samples to 8 bits, packs two
// pixels per word and writes 32 words to SRAM. All outputs are registered.
module write_s_block
  import write_s_block_pkg::*;
(
  input  logic           CLOCK_50_I,
  input  logic           Reset,
  write_s_block_if.slave ws
);

  WS_state_type     state_q, state_d;
  logic [4:0]       word_cnt_q, word_cnt_d;
  logic [1:0][6:0]  ram_addr_q, ram_addr_d;
  logic [17:0]      sram_addr_q, sram_addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             we_n_q, we_n_d;
  logic             done_q, done_d;
  logic             mem_end_q, mem_end_d;
  logic             step_word, step_row, step_block;
  logic [17:0]      gen_addr;
  logic             gen_last;
  logic [1:0][7:0]  px;

  ws_address_gen u_addr_gen (
    .clk_i        (CLOCK_50_I),
    .rst_i        (Reset),
    .step_word_i  (step_word),
    .step_row_i   (step_row),
    .step_block_i (step_block),
    .addr_o       (gen_addr),
    .last_block_o (gen_last)
  );

  // Clip each signed sample to 0..255
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      px[p] = ws.WS_RAM_read_data[p][7:0];
      if (ws.WS_RAM_read_data[p][31])
        px[p] = 8'd0;
      else if (|ws.WS_RAM_read_data[p][30:8])
        px[p] = 8'd255;
    end
  end

  // FSM next state and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    ram_addr_d  = ram_addr_q;
    sram_addr_d = sram_addr_q;
    wdata_d     = wdata_q;
    we_n_d      = 1'b1;
    done_d      = 1'b0;
    mem_end_d   = 1'b0;
    step_word   = 1'b0;
    step_row    = 1'b0;
    step_block  = 1'b0;
    // Read pointer runs two DPRAM cycles ahead of the write; stops at pair 31
    if ((state_q inside {S_WS_LI0, S_WS_LI1, S_WS_WRITE}) &&
        (ram_addr_q[0] != LAST_PAIR_ADDR)) begin
      ram_addr_d[0] = ram_addr_q[0] + 7'd2;
      ram_addr_d[1] = ram_addr_q[1] + 7'd2;
    end
    case (state_q)
      S_WS_IDLE: begin
        if (ws.WS_start) begin
          state_d       = S_WS_LI0;
          word_cnt_d    = 5'd0;
          ram_addr_d[0] = S_OFFSET;
          ram_addr_d[1] = S_OFFSET + 7'd1;
        end
      end
      S_WS_LI0: state_d = S_WS_LI1;
      S_WS_LI1: state_d = S_WS_WRITE;
      S_WS_WRITE: begin
        we_n_d      = 1'b0;
        sram_addr_d = gen_addr;
        wdata_d     = {px[0], px[1]};
        step_word   = 1'b1;
        step_row    = (word_cnt_q[1:0] == 2'd3);
        word_cnt_d  = word_cnt_q + 5'd1;
        if (word_cnt_q == 5'd31) state_d = S_WS_LO;
      end
      S_WS_LO: begin
        done_d     = 1'b1;
        mem_end_d  = gen_last;
        step_block = 1'b1;
        state_d    = S_WS_IDLE;
      end
      default: state_d = S_WS_IDLE;
    endcase
  end

  // State and output registers; reset aborts any block in progress
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state_q     <= S_WS_IDLE;
      word_cnt_q  <= 5'd0;
      ram_addr_q  <= '0;
      sram_addr_q <= 18'd0;
      wdata_q     <= 16'd0;
      we_n_q      <= 1'b1;
      done_q      <= 1'b0;
      mem_end_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      ram_addr_q  <= ram_addr_d;
      sram_addr_q <= sram_addr_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
      done_q      <= done_d;
      mem_end_q   <= mem_end_d;
    end
  end

  assign ws.WS_done         = done_q;
  assign ws.WS_memory_end   = mem_end_q;
  assign ws.WS_RAM_address  = ram_addr_q;
  assign ws.SRAM_address    = sram_addr_q;
  assign ws.SRAM_write_data = wdata_q;
  assign ws.SRAM_we_n       = we_n_q;
  assign ws.ws_state        = state_q;

endmodule

// File: tb/tb_write_s_block.sv
// Directed bench for write_s_block: reset values, block data/addressing,
// clipping, block ordering over all planes, ignored restart and mid-block reset.
module tb_write_s_block;
  import write_s_block_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  write_s_block_if ws_if ();

  write_s_block dut (
    .CLOCK_50_I (clk),
    .Reset      (rst),
    .ws         (ws_if)
  );

  // S DPRAM model: address register plus output register on each port
  logic [31:0]      s_mem [0:127];
  logic [1:0][6:0]  ram_a_q;
  logic [1:0][31:0] ram_q;
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      ram_a_q[p] <= ws_if.WS_RAM_address[p];
      ram_q[p]   <= s_mem[ram_a_q[p]];
    end
  end
  assign ws_if.WS_RAM_read_data = ram_q;

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [33:0] act_q[$];
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference address: direct multiply form of the raster layout
  function automatic logic [17:0] exp_addr(input int b, input int k);
    int bb, base, wpr, cols;
    bb = b % 2400;
    if (bb < 1200) begin base = 0; wpr = 160; cols = 40; end
    else if (bb < 1800) begin base = 38400; wpr = 80; cols = 20; bb -= 1200; end
    else begin base = 57600; wpr = 80; cols = 20; bb -= 1800; end
    return 18'(base + (8 * (bb / cols) + k / 4) * wpr + 4 * (bb % cols) + k % 4);
  endfunction

  function automatic logic [17:0] word_addr(input int k);
    logic [33:0] w;
    w = act_q[k];
    return w[33:16];
  endfunction

  // ---------------- driver ----------------
  // Entered on a negedge. Pulses WS_start, collects writes until WS_done
  // (bounded), optionally re-pulses start at cycle pulse_at, or raises Reset
  // right after write index reset_at is seen and returns at once.
  task automatic run_block(input int pulse_at, input int reset_at,
                           output int n_wr, output int first_cyc,
                           output int done_cyc, output logic me);
    int cyc;
    n_wr = 0; first_cyc = -1; done_cyc = -1; me = 1'b0;
    act_q.delete();
    ws_if.WS_start = 1'b1;
    @(negedge clk);
    ws_if.WS_start = 1'b0;
    cyc = 0;
    while (done_cyc < 0 && cyc < 60) begin
      if (!ws_if.SRAM_we_n) begin
        if (first_cyc < 0) first_cyc = cyc;
        act_q.push_back({ws_if.SRAM_address, ws_if.SRAM_write_data});
        n_wr++;
        if (reset_at >= 0 && n_wr == reset_at + 1) begin
          rst = 1'b1;
          return;
        end
      end
      if (ws_if.WS_done) begin
        done_cyc = cyc;
        me = ws_if.WS_memory_end;
      end
      ws_if.WS_start = (cyc == pulse_at);
      if (done_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    ws_if.WS_start = 1'b0;
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    int n_wr, f_cyc, d_cyc, extra;
    int bad_addr, bad_blk, bad_me, me_cnt;
    logic me;
    logic [33:0] e, a;

    rst = 1'b1;
    ws_if.WS_start = 1'b0;
    for (int i = 0; i < 128; i++) s_mem[i] = 32'(i);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", 64'(ws_if.ws_state), 64'(S_WS_IDLE));
    check("rst_we_n", ws_if.SRAM_we_n, 1);
    check("rst_done", ws_if.WS_done, 0);
    check("rst_mem_end", ws_if.WS_memory_end, 0);
    check("rst_sram_addr", ws_if.SRAM_address, 0);
    check("rst_wdata", ws_if.SRAM_write_data, 0);
    check("rst_ram_addr", ws_if.WS_RAM_address, 0);
    rst = 1'b0;
    @(negedge clk);

    // Start re-pulsed during WRITE is ignored
    run_block(10, -1, n_wr, f_cyc, d_cyc, me);
    check("t5_nwr", n_wr, 32);
    check("t5_done_cyc", d_cyc, 35);
    if (n_wr == 32) check("t5_last_addr", word_addr(31), 1123);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (!ws_if.SRAM_we_n || ws_if.WS_done) extra++;
    end
    check("t5_quiet_after_done", extra, 0);

    // Reset on write 10 of block 1
    run_block(-1, 10, n_wr, f_cyc, d_cyc, me);
    check("t6_nwr_before_rst", n_wr, 11);
    if (n_wr > 0) check("t6_first_addr", word_addr(0), 4);
    @(negedge clk);
    check("t6_we_n_after_rst", ws_if.SRAM_we_n, 1);
    check("t6_done_after_rst", ws_if.WS_done, 0);
    check("t6_state_after_rst", 64'(ws_if.ws_state), 64'(S_WS_IDLE));
    rst = 1'b0;

    // Full sweep of all planes from Y(0,0), plus the wrap block
    bad_addr = 0; bad_blk = 0; bad_me = 0; me_cnt = 0;
    for (int b = 0; b <= 2401; b++) begin
      if (b == 1) begin
        s_mem[0] = 32'hFFFF_FFFF;  // -1
        s_mem[1] = 32'd256;
        s_mem[2] = 32'd255;
        s_mem[3] = 32'd0;
        s_mem[4] = 32'h8000_0000;
        s_mem[5] = 32'h7FFF_FFFF;
        s_mem[6] = 32'd128;
        s_mem[7] = 32'hFFFF_FF00;  // -256
      end
      run_block(-1, -1, n_wr, f_cyc, d_cyc, me);

      if (b == 0) begin
        check("t1_first_we_cyc", f_cyc, 3);
        check("t1_done_cyc", d_cyc, 35);
        for (int k = 0; k < 32; k++)
          exp_q.push_back({exp_addr(0, k), 8'(2 * k), 8'(2 * k + 1)});
        check("t1_nwr", act_q.size(), 32);
        while (exp_q.size() > 0 && act_q.size() > 0) begin
          e = exp_q.pop_front();
          a = act_q.pop_front();
          check("t1_word", a, e);
        end
        exp_q.delete();
      end else if (b == 1) begin
        check("t2_nwr", n_wr, 32);
        exp_q.push_back({18'd4, 16'h00FF});
        exp_q.push_back({18'd5, 16'hFF00});
        exp_q.push_back({18'd6, 16'h00FF});
        exp_q.push_back({18'd7, 16'h8000});
        exp_q.push_back({18'd164, 16'h0809});
        for (int k = 0; k < 5 && k < act_q.size(); k++) begin
          e = exp_q.pop_front();
          check("t2_clip_word", act_q[k], e);
        end
        exp_q.delete();
      end

      if (n_wr != 32 || d_cyc != 35) bad_blk++;
      for (int k = 0; k < act_q.size() && b > 0; k++)
        if (word_addr(k) != exp_addr(b, k)) bad_addr++;
      if (me != (b == 2399)) bad_me++;
      if (me) me_cnt++;

      if (b == 40 && n_wr > 0)   check("t3_blk40_first", word_addr(0), 1280);
      if (b == 1200 && n_wr > 0) check("t3_blk1200_first", word_addr(0), 38400);
      if (b == 1799 && n_wr == 32) check("t3_blk1799_last", word_addr(31), 38400 + 80 * 239 + 79);
      if (b == 2399) begin
        check("t4_mem_end_last_v", me, 1);
        if (n_wr == 32) check("t4_last_addr", word_addr(31), 76799);
      end
      if (b == 2400) begin
        if (n_wr > 0) check("t4_wrap_first", word_addr(0), 0);
        check("t4_wrap_mem_end", me, 0);
      end
    end
    check("sweep_bad_addr", bad_addr, 0);
    check("sweep_bad_blocks", bad_blk, 0);
    check("sweep_bad_mem_end", bad_me, 0);
    check("sweep_mem_end_count", me_cnt, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
